// File: rtl/imem_loader.sv
// Boot-time loader: turns a header-prefixed byte stream into big-endian 32-bit
// instruction ROM writes, holding the core in reset until the image is complete.
module imem_loader #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              start,
   output logic              wr_en,
   output logic [31:0]       wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_run,
   output logic              error,
   output logic [ADDR_W:0]   load_count
);

   typedef enum logic [1:0] {
      HDR  = 2'd0,
      DATA = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0]   LC_ONE = (ADDR_W+1)'(1'b1);
   localparam logic [ADDR_W-1:0] WI_ONE = ADDR_W'(1'b1);
   localparam logic [10:0]       DEPTH_W = 11'(DEPTH);

   state_t              state_r, next_state_s;
   logic                in_ready_s;
   logic                hs_s;
   logic [10:0]         hdr_n_s;
   logic                hdr_ok_s, hdr_bad_s, byte_s, word_done_s, restart_s, last_s;

   logic [ADDR_W:0]     count_r;
   logic [ADDR_W:0]     load_count_r;
   logic [ADDR_W-1:0]   word_idx_r;
   logic [1:0]          byte_idx_r;
   logic [23:0]         shift_r;
   logic                wr_en_r, cpu_run_r, error_r;
   logic [31:0]         wr_addr_r, wr_data_r;

   assign hs_s    = in_valid && in_ready_s;
   // A zero header byte stands for a full-depth image.
   assign hdr_n_s = (in_data == 8'd0) ? DEPTH_W : {3'b000, in_data};
   assign last_s  = ((load_count_r + LC_ONE) == count_r);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= HDR;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state, ready decode and datapath strobes.
   always_comb begin
      next_state_s = state_r;
      in_ready_s   = 1'b0;
      hdr_ok_s     = 1'b0;
      hdr_bad_s    = 1'b0;
      byte_s       = 1'b0;
      word_done_s  = 1'b0;
      restart_s    = 1'b0;
      case (state_r)
         HDR: begin
            in_ready_s = 1'b1;
            if (hs_s) begin
               if (hdr_n_s > DEPTH_W) begin
                  hdr_bad_s    = 1'b1;
                  next_state_s = ERR;
               end else begin
                  hdr_ok_s     = 1'b1;
                  next_state_s = DATA;
               end
            end else begin
               next_state_s = HDR;
            end
         end
         DATA: begin
            in_ready_s = 1'b1;
            if (hs_s) begin
               byte_s = 1'b1;
               if (byte_idx_r == 2'd3) begin
                  word_done_s  = 1'b1;
                  next_state_s = last_s ? DONE : DATA;
               end else begin
                  next_state_s = DATA;
               end
            end else begin
               next_state_s = DATA;
            end
         end
         DONE: begin
            if (start) begin
               restart_s    = 1'b1;
               next_state_s = HDR;
            end else begin
               next_state_s = DONE;
            end
         end
         ERR: begin
            next_state_s = ERR;
         end
         default: begin
            next_state_s = HDR;
         end
      endcase
   end

   // Word assembly, write port and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r      <= '0;
         load_count_r <= '0;
         word_idx_r   <= '0;
         byte_idx_r   <= 2'd0;
         shift_r      <= 24'd0;
         wr_en_r      <= 1'b0;
         wr_addr_r    <= 32'd0;
         wr_data_r    <= 32'd0;
         cpu_run_r    <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         wr_en_r <= 1'b0;
         if (hdr_ok_s) begin
            count_r      <= hdr_n_s[ADDR_W:0];
            load_count_r <= '0;
            word_idx_r   <= '0;
            byte_idx_r   <= 2'd0;
         end else if (restart_s) begin
            load_count_r <= '0;
            word_idx_r   <= '0;
            byte_idx_r   <= 2'd0;
         end else if (word_done_s) begin
            wr_en_r      <= 1'b1;
            wr_addr_r    <= {{(30-ADDR_W){1'b0}}, word_idx_r, 2'b00};
            wr_data_r    <= {shift_r, in_data};
            word_idx_r   <= word_idx_r + WI_ONE;
            load_count_r <= load_count_r + LC_ONE;
            byte_idx_r   <= 2'd0;
         end else if (byte_s) begin
            shift_r    <= {shift_r[15:0], in_data};
            byte_idx_r <= byte_idx_r + 2'd1;
         end
         // Sampling the current state delays release until after the last write.
         cpu_run_r <= (state_r == DONE) && !start;
         error_r   <= error_r || hdr_bad_s;
      end
   end

   assign in_ready   = in_ready_s;
   assign wr_en      = wr_en_r;
   assign wr_addr    = wr_addr_r;
   assign wr_data    = wr_data_r;
   assign cpu_run    = cpu_run_r;
   assign error      = error_r;
   assign load_count = load_count_r;

endmodule
